fsqrt_arbiter: RTL

// - Shares one pipelined fsqrt unit between NREQ independent requesters (FPU issue ports).
// - Round-robin selection of one request per cycle. Issues it through a registered port so fsqrt's BRAM address is stable.
// - Tags each issued operation with its requester ID. Steers each result into that requester's response queue.
// - Credit accounting guarantees a result never finds its response queue full.

---
 rtl/fpu_arb_pkg.sv | 21 ++
 rtl/fsqrt_rsp_fifo.sv | 56 +++++
 rtl/fsqrt_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/fpu_arb_pkg.sv
// Shared types for the fsqrt arbiter: the operand word, the result-routing tag
// and a small modular-index helper.
package fpu_arb_pkg;

   localparam int NREQ_MAX = 8;
   // Tags are sized for the widest supported arbiter, so every instance shares one tag type.
   localparam int ID_W = $clog2(NREQ_MAX);

   typedef logic [31:0] fp32_t;

   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
   } fs_tag_t;

   // Reduces a + b into [0, n), given a < n and b <= n.
   function automatic int wrap_idx(input int a, input int b, input int n);
      return (a + b >= n) ? a + b - n : a + b;
   endfunction

endpackage

// File: rtl/fsqrt_rsp_fifo.sv
// Per-requester response queue: power-of-two FIFO with registered head.
// A push into an empty queue becomes visible on the following cycle.
module fsqrt_rsp_fifo
   import fpu_arb_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             sys_clk,
   input  logic             rstn,
   input  logic             push,
   input  fp32_t            push_data,
   input  logic             pop,
   output logic             valid,
   output fp32_t            head,
   output logic [CNT_W-1:0] count
);

   fp32_t            mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_pop;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      do_pop   = pop && (count_q != '0);
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
      count_d  = count_q + CNT_W'(push) - CNT_W'(do_pop);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge sys_clk) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is not reset; count_q qualifies every read, so stale words are never observed.
   always_ff @(posedge sys_clk) begin
      if (push) mem_q[wr_ptr_q] <= push_data;
   end

   assign valid = (count_q != '0);
   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/fsqrt_arbiter.sv
// Round-robin sharing of one pipelined fsqrt among NREQ requesters; results are
// steered back through a tag pipeline and credit-protected response queues.
module fsqrt_arbiter
   import fpu_arb_pkg::*;
#(
   parameter int NREQ       = 4,
   parameter int FS_LAT     = 3,
   parameter int RSPQ_DEPTH = 4
) (
   input  logic                  sys_clk,
   input  logic                  rstn,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ-1:0][31:0] req_x,
   output logic [NREQ-1:0]       req_ready,
   output logic [NREQ-1:0]       rsp_valid,
   output logic [NREQ-1:0][31:0] rsp_y,
   input  logic [NREQ-1:0]       rsp_ready,
   output logic                  fs_valid,
   output logic [31:0]           fs_x,
   input  logic [31:0]           fs_y,
   input  logic                  fs_out_valid,
   output logic                  busy,
   output logic                  tag_err
);

   localparam int CNT_W = $clog2(RSPQ_DEPTH) + 1;

   logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic             fs_valid_q, fs_valid_d;
   fp32_t            fs_x_q, fs_x_d;
   logic             tag_err_q, tag_err_d;
   fs_tag_t          tag_q [FS_LAT+1];
   fs_tag_t          tag_d [FS_LAT+1];
   logic [CNT_W-1:0] inflight_q [NREQ];
   logic [CNT_W-1:0] inflight_d [NREQ];
   logic [CNT_W-1:0] rsp_count  [NREQ];

   logic [NREQ-1:0]  eligible, rot, grant, release_v, push;
   logic             found, grant_any;
   logic [ID_W-1:0]  first_k, grant_id;
   fs_tag_t          tail;

   // Rotate eligibility so rr_ptr sits at bit 0, take the lowest set bit, rotate back.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      eligible = '0;
      rot      = '0;
      grant    = '0;
      found    = 1'b0;
      first_k  = '0;
      for (int i = 0; i < NREQ; i++) begin
         eligible[i] = req_valid[i] &&
            ((CNT_W+1)'(inflight_q[i]) + (CNT_W+1)'(rsp_count[i]) < (CNT_W+1)'(RSPQ_DEPTH));
      end
      for (int k = 0; k < NREQ; k++) begin
         rot[k] = eligible[wrap_idx(k, int'(rr_ptr_q), NREQ)];
      end
      for (int k = 0; k < NREQ; k++) begin
         if (!found && rot[k]) begin
            found   = 1'b1;
            first_k = ID_W'(k);
         end
      end
      grant_any = found && rstn;
      grant_id  = ID_W'(wrap_idx(int'(first_k), int'(rr_ptr_q), NREQ));
      for (int i = 0; i < NREQ; i++) begin
         grant[i] = grant_any && (int'(grant_id) == i);
      end
   end

   always_comb begin
      rr_ptr_d   = grant_any ? ID_W'(wrap_idx(int'(grant_id), 1, NREQ)) : rr_ptr_q;
      fs_valid_d = grant_any;
      fs_x_d     = fs_x_q;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) fs_x_d = req_x[i];
      end

      tag_d[0].valid = grant_any;
      tag_d[0].id    = grant_id;
      for (int k = 1; k <= FS_LAT; k++) begin
         tag_d[k] = tag_q[k-1];
      end
      tail      = tag_q[FS_LAT];
      tag_err_d = tag_err_q || (fs_out_valid != tail.valid);

      // A valid tail frees its credit even if fsqrt failed to deliver; the result is then dropped.
      for (int i = 0; i < NREQ; i++) begin
         release_v[i]  = tail.valid && (int'(tail.id) == i);
         push[i]       = release_v[i] && fs_out_valid;
         inflight_d[i] = inflight_q[i] + CNT_W'(grant[i]) - CNT_W'(release_v[i]);
      end
   end

   always_ff @(posedge sys_clk) begin
      if (!rstn) begin
         rr_ptr_q   <= '0;
         fs_valid_q <= 1'b0;
         fs_x_q     <= '0;
         tag_err_q  <= 1'b0;
         for (int k = 0; k <= FS_LAT; k++) tag_q[k] <= '0;
         for (int i = 0; i < NREQ; i++) inflight_q[i] <= '0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         fs_valid_q <= fs_valid_d;
         fs_x_q     <= fs_x_d;
         tag_err_q  <= tag_err_d;
         for (int k = 0; k <= FS_LAT; k++) tag_q[k] <= tag_d[k];
         for (int i = 0; i < NREQ; i++) inflight_q[i] <= inflight_d[i];
      end
   end

   for (genvar i = 0; i < NREQ; i++) begin : g_rspq
      fsqrt_rsp_fifo #(.DEPTH(RSPQ_DEPTH)) u_fifo (
         .sys_clk   (sys_clk),
         .rstn      (rstn),
         .push      (push[i]),
         .push_data (fs_y),
         .pop       (rsp_ready[i]),
         .valid     (rsp_valid[i]),
         .head      (rsp_y[i]),
         .count     (rsp_count[i])
      );
   end

   always_comb begin
      busy = |rsp_valid;
      for (int i = 0; i < NREQ; i++) begin
         if (inflight_q[i] != '0) busy = 1'b1;
      end
   end

   assign req_ready = grant;
   assign fs_valid  = fs_valid_q;
   assign fs_x      = fs_x_q;
   assign tag_err   = tag_err_q;

endmodule
